// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH independent programmable clock dividers.
// Each channel produces a one-cycle tick enable and a square wave that
// toggles on every tick. Divisor writes are held in a shadow register and
// applied at the channel's next wrap, or immediately on clr.
`timescale 1ns/1ps

module clk_div_bank #(
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 27,
   parameter int DEF_DIV = 25000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   input  logic              cfg_we,
   input  logic [3:0]        cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   output logic [NUM_CH-1:0] cfg_pend,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] sq
);

   localparam logic [CNT_W-1:0] DEF_DIV_W = CNT_W'(DEF_DIV);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [CNT_W-1:0] cnt_reg, cnt_next;
         logic [CNT_W-1:0] act_div_reg, act_div_next;
         logic [CNT_W-1:0] shd_div_reg, shd_div_next;
         logic             pend_reg, pend_next;
         logic             tick_reg, tick_next;
         logic             sq_reg, sq_next;
         logic             wr_hit;
         logic             wrap;

         // Out-of-range channel numbers never match any gi, so they are ignored.
         assign wr_hit = cfg_we && (cfg_ch == 4'(gi));
         // Full-width equality; a zero divisor never wraps.
         assign wrap   = (act_div_reg != '0) && (cnt_reg == act_div_reg - CNT_W'(1));

         // Next-state: clr beats en; a write on the same edge as an
         // application lands in the shadow and stays pending.
         always_comb begin
            cnt_next     = cnt_reg;
            act_div_next = act_div_reg;
            shd_div_next = shd_div_reg;
            pend_next    = pend_reg;
            tick_next    = 1'b0;
            sq_next      = sq_reg;
            if (clr) begin
               cnt_next = '0;
               sq_next  = 1'b0;
               if (wr_hit) begin
                  act_div_next = cfg_div;
                  shd_div_next = cfg_div;
                  pend_next    = 1'b0;
               end else if (pend_reg) begin
                  act_div_next = shd_div_reg;
                  pend_next    = 1'b0;
               end
            end else begin
               if (en) begin
                  if (act_div_reg == '0) begin
                     // Disabled channel: no wrap needed to pick up a new divisor.
                     cnt_next = '0;
                     if (pend_reg) begin
                        act_div_next = shd_div_reg;
                        pend_next    = 1'b0;
                     end
                  end else if (wrap) begin
                     cnt_next  = '0;
                     tick_next = 1'b1;
                     sq_next   = ~sq_reg;
                     if (pend_reg) begin
                        act_div_next = shd_div_reg;
                        pend_next    = 1'b0;
                     end
                  end else begin
                     cnt_next = cnt_reg + CNT_W'(1);
                  end
               end
               if (wr_hit) begin
                  shd_div_next = cfg_div;
                  pend_next    = 1'b1;
               end
            end
         end

         // Channel state registers with asynchronous reset to the default divisor.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_reg     <= '0;
               act_div_reg <= DEF_DIV_W;
               shd_div_reg <= DEF_DIV_W;
               pend_reg    <= 1'b0;
               tick_reg    <= 1'b0;
               sq_reg      <= 1'b0;
            end else begin
               cnt_reg     <= cnt_next;
               act_div_reg <= act_div_next;
               shd_div_reg <= shd_div_next;
               pend_reg    <= pend_next;
               tick_reg    <= tick_next;
               sq_reg      <= sq_next;
            end
         end

         assign cfg_pend[gi] = pend_reg;
         assign tick[gi]     = tick_reg;
         assign sq[gi]       = sq_reg;
      end
   endgenerate

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Parametrised multi-channel successor to the single fixed divide-by-25M toggle generator.
- Generates NUM_CH independent slow timing signals from the 100 MHz system clock. Each channel has:
  - a runtime-programmable divisor,
  - a one-cycle tick enable for logic running in the clk domain,
  - a 50%-style square output for LEDs and display scanning.
- Divisor updates are glitch-free: they are shadowed and applied at the channel's next wrap.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 27, width of per-channel counter and divisor (holds up to 100M).
- DEF_DIV, 25000000, divisor loaded into every channel at reset.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global run; when 0, all channels freeze.
- clr  input  1  synchronous restart of all channels' phase.
- cfg_we  input  1  divisor write strobe, one cycle.
- cfg_ch  input  4  target channel of the write; values >= NUM_CH are ignored.
- cfg_div  input  CNT_W  new divisor value.
- cfg_pend  output  NUM_CH  bit i = 1 while a written divisor awaits application.
- tick  output  NUM_CH  one-cycle pulse per channel period.
- sq  output  NUM_CH  square output, toggles on every tick.

Behaviour:
- Reset (rst_n=0, async), per channel:
  - cnt=0, act_div=DEF_DIV, shd_div=DEF_DIV
  - cfg_pend=0, tick=0, sq=0
- All outputs are registered.
- Per channel, on each clk edge with en=1, clr=0, act_div!=0:
  - if cnt==act_div-1: cnt<=0, tick<=1, sq<=~sq, and act_div<=shd_div if pend.
  - else: cnt<=cnt+1, tick<=0.
- Timing: with DIV=N, tick is high for the cycle following edges N, 2N, 3N… counted from the first enabled edge. Period is N cycles. sq period is 2N cycles.
- DIV=1: tick is constantly 1 and sq toggles every cycle.
- act_div==0 means the channel is disabled:
  - cnt held at 0, tick=0, sq held.
  - A pending divisor is applied on the next edge (no wrap needed).
- en=0:
  - cnt, sq and act_div hold; tick<=0.
  - Pending writes stay pending.
- clr=1 has priority over en. For all channels: cnt<=0, tick<=0, sq<=0, and a pending shd_div is applied immediately.
- Config write (cfg_we=1, cfg_ch<NUM_CH): shd_div[cfg_ch]<=cfg_div, cfg_pend[cfg_ch]<=1.
- cfg_pend clears on the edge where shd_div is copied to act_div.
- Write and wrap on the same edge, same channel:
  - act_div takes the old shd_div (pending before this edge, if any).
  - The new value is stored in shd_div and pend stays 1, so it is applied at the following wrap.
- Write and clr on the same edge: the written value goes directly to act_div; pend=0.
- Repeated writes before a wrap: the last write wins; only one application occurs.
- Out-of-range cfg_ch: no state changes.
- Counter compare uses a full CNT_W-bit equality. cnt never exceeds act_div-1 because divisors change only at wrap or clr.
- Reset asserted mid-period: immediate return to reset values, with no tick emitted.

Test Plan:
- Bench uses DEF_DIV=4, NUM_CH=4, CNT_W=8.
- Reset release, en=1: every channel's tick is high after edges 4, 8, 12. sq is 0→1 at edge 4 and 1→0 at edge 8. cfg_pend=0.
- Write div=2 to ch1 at edge 2 (mid-period):
  - ch1 still ticks at edge 4 (old period) and cfg_pend[1]=1 until edge 4.
  - ch1 then ticks at edges 6, 8, 10; other channels are unaffected.
- Write div=0 to ch2: after its next wrap, ch2 tick stays 0 and sq holds. Writing div=3 then resumes ticks every 3 cycles starting from the cycle after the write.
- en=0 for 5 cycles mid-period (cnt=2): no ticks and sq held. After en=1, the first tick arrives 2 cycles later.
- Write ch0 div=6 on the same edge as clr: ch0 cnt=0, sq=0, cfg_pend[0]=0, next tick after 6 edges. Repeat with the write coincident with a wrap instead: ch0 pend stays 1 for one further period.
- Assert rst_n low between clock edges at cnt=3: outputs go to reset values asynchronously, with no tick emitted. After release, a write to cfg_ch=7 changes nothing.
